// File: rtl/icblbc_results_reader.sv
// ICBLBC results reader: once a dump is started, streams a header word holding
// the codeword count, then every stored codeword read from the results RAM,
// over a valid/ready handshake. A 2-entry skid FIFO absorbs the one-cycle RAM
// read latency, so the sink can stall at any time without losing data.
module icblbc_results_reader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] result_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_STREAM, ST_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   accepted;
  logic              vld_p1;
  logic [1:0]        occ;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [DATA_W-1:0] fifo_mem [2];

  logic       pop;
  logic       last_data;
  logic [1:0] pending;
  logic       room;

  // A slot is free when buffered plus in-flight words leave space; a
  // same-cycle pop counts as space so the stream runs at full rate.
  always_comb begin
    pop       = (state == ST_STREAM) && (occ != 2'd0) && out_ready;
    last_data = ((accepted + (ADDR_W+1)'(1)) == {1'b0, cnt});
    pending   = occ + 2'(vld_p1);
    room      = (pending < 2'd2) || pop;
    ram_rd    = 1'b0;
    case (state)
      ST_IDLE:   ram_rd = start && (result_count != '0);
      ST_HEADER,
      ST_STREAM: ram_rd = (issued < {1'b0, cnt}) && room;
      default:   ram_rd = 1'b0;
    endcase
  end

  // Stream outputs are decoded from registered state only, so they stay
  // stable while the sink stalls and clear as soon as reset asserts.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      ST_HEADER: begin
        out_data  = DATA_W'(cnt);
        out_valid = 1'b1;
        out_last  = (cnt == '0);
      end
      ST_STREAM: begin
        out_data  = fifo_mem[rd_ptr];
        out_valid = (occ != 2'd0);
        out_last  = (occ != 2'd0) && last_data;
      end
      default: ;
    endcase
    busy = (state == ST_HEADER) || (state == ST_STREAM);
    done = (state == ST_DONE);
  end

  // Control: FSM, read address/counters and FIFO bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      issued   <= '0;
      accepted <= '0;
      vld_p1   <= 1'b0;
      occ      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      ram_addr <= BASE_ADDR;
    end else begin
      // ---- p1: RAM data returns one cycle after the read strobe ----
      vld_p1 <= ram_rd;
      if (ram_rd) begin
        ram_addr <= ram_addr + ADDR_W'(1);
        issued   <= issued + (ADDR_W+1)'(1);
      end
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        accepted <= accepted + (ADDR_W+1)'(1);
      end
      occ <= occ + 2'(vld_p1) - 2'(pop);
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= result_count;
            state <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (out_ready) state <= (cnt == '0) ? ST_DONE : ST_STREAM;
        end
        ST_STREAM: begin
          if (pop && last_data) state <= ST_DONE;
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          issued   <= '0;
          accepted <= '0;
          ram_addr <= BASE_ADDR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data: skid FIFO storage, written with the returning RAM word.
  always_ff @(posedge clock) begin
    if (vld_p1) fifo_mem[wr_ptr] <= ram_q;
  end

endmodule

// File: tb/tb_icblbc_results_reader.sv
// Directed bench for icblbc_results_reader: a registered RAM model, a monitor
// that records every accepted word, and hand-computed expected streams.
module tb_icblbc_results_reader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] result_count;
  logic [7:0] ram_addr;
  logic       ram_rd;
  logic [7:0] ram_q;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  icblbc_results_reader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'd0)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .result_count(result_count),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] ram_mem [256];

  function automatic logic [7:0] exp_ram(input int a);
    logic [7:0] v;
    case (a)
      0: v = 8'h11;
      1: v = 8'h22;
      2: v = 8'h33;
      3: v = 8'h44;
      4: v = 8'h55;
      default: v = 8'(a) ^ 8'hA5;
    endcase
    return v;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (ram_rd) ram_q <= ram_mem[ram_addr];
  end

  // Monitor state
  logic       clr = 1'b0;
  int         nwords, rd_total, done_cnt, stab_err, max_out, outst;
  logic [7:0] words [300];
  logic       lasts [300];
  int         acc_cyc [300];
  int         rd_cnt [256];
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clock) begin
    if (clr) begin
      nwords = 0; rd_total = 0; done_cnt = 0; stab_err = 0; max_out = 0;
      prev_stall = 1'b0;
      for (int a = 0; a < 256; a++) rd_cnt[a] = 0;
    end else if (reset_n) begin
      if (prev_stall && (!out_valid || out_data != prev_data || out_last != prev_last))
        stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (ram_rd) begin
        rd_total++;
        rd_cnt[ram_addr]++;
      end
      if (out_valid && out_ready && nwords < 300) begin
        words[nwords]   = out_data;
        lasts[nwords]   = out_last;
        acc_cyc[nwords] = cyc;
        nwords++;
      end
      if (done) done_cnt++;
      outst = rd_total - ((nwords > 0) ? nwords - 1 : 0);
      if (outst > max_out) max_out = outst;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    clr = 1'b1;
    @(negedge clock);
    #1 clr = 1'b0;
  endtask

  int st_cyc;

  // mode 0: out_ready held high; mode 1: out_ready high ~30% of cycles
  task automatic run_dump(input logic [7:0] n, input int mode, input int budget);
    @(posedge clock); #1;
    start = 1'b1;
    result_count = n;
    st_cyc = cyc;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      out_ready = (mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    if (done_cnt == 0) check("dump_timeout", 0, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  int bad, nlast;

  initial begin
    for (int a = 0; a < 256; a++) ram_mem[a] = exp_ram(a);
    reset_n = 1'b0; start = 1'b0; result_count = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_addr",  32'(ram_addr), 0);
    check("rst_rd",    32'(ram_rd), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last",  32'(out_last), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    @(negedge clock);
    reset_n = 1'b1;
    clear_stats();

    // Three codewords, sink always ready
    run_dump(8'd3, 0, 50);
    check("t1_nwords", 32'(nwords), 4);
    check("t1_w0", 32'(words[0]), 32'h03);
    check("t1_w1", 32'(words[1]), 32'h11);
    check("t1_w2", 32'(words[2]), 32'h22);
    check("t1_w3", 32'(words[3]), 32'h33);
    check("t1_last", {28'd0, lasts[3], lasts[2], lasts[1], lasts[0]}, 32'b1000);
    check("t1_hdr_lat", 32'(acc_cyc[0] - st_cyc), 1);
    check("t1_back2back", 32'(acc_cyc[3] - acc_cyc[0]), 3);
    check("t1_done", 32'(done_cnt), 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_reads", 32'(rd_total), 3);
    clear_stats();

    // Empty dump: header only
    run_dump(8'd0, 0, 20);
    check("t2_nwords", 32'(nwords), 1);
    check("t2_w0", 32'(words[0]), 0);
    check("t2_last", 32'(lasts[0]), 1);
    check("t2_reads", 32'(rd_total), 0);
    check("t2_done", 32'(done_cnt), 1);
    clear_stats();

    // Five codewords under random backpressure
    run_dump(8'd5, 1, 400);
    check("t3_nwords", 32'(nwords), 6);
    check("t3_hdr", 32'(words[0]), 5);
    for (int k = 1; k < 6; k++) check($sformatf("t3_w%0d", k), 32'(words[k]), 32'(exp_ram(k - 1)));
    nlast = 0;
    for (int k = 0; k < 6; k++) nlast += int'(lasts[k]);
    check("t3_nlast", 32'(nlast), 1);
    check("t3_lastpos", 32'(lasts[5]), 1);
    check("t3_stable", 32'(stab_err), 0);
    check("t3_outst_le2", 32'(max_out <= 2), 1);
    check("t3_done", 32'(done_cnt), 1);
    clear_stats();

    // Full-size dump: 255 codewords
    run_dump(8'd255, 0, 600);
    check("t4_nwords", 32'(nwords), 256);
    check("t4_hdr", 32'(words[0]), 255);
    bad = 0;
    for (int k = 1; k < 256; k++) if (words[k] !== exp_ram(k - 1)) bad++;
    check("t4_bad_words", 32'(bad), 0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (rd_cnt[a] != ((a < 255) ? 1 : 0)) bad++;
    check("t4_bad_addrs", 32'(bad), 0);
    nlast = 0;
    for (int k = 0; k < 256; k++) nlast += int'(lasts[k]);
    check("t4_nlast", 32'(nlast), 1);
    check("t4_lastpos", 32'(lasts[255]), 1);
    check("t4_rate", 32'(acc_cyc[255] - acc_cyc[0]), 255);
    check("t4_done", 32'(done_cnt), 1);
    clear_stats();

    // Extra start pulses while busy and in the done cycle are ignored
    @(posedge clock); #1;
    start = 1'b1; result_count = 8'd3; out_ready = 1'b1;
    @(posedge clock); #1;
    result_count = 8'd7;
    @(posedge clock); #1;
    start = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clock);
        if (done) seen = 1'b1;
      end
      if (!seen) check("t5_timeout", 0, 1);
    end
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("t5_nwords", 32'(nwords), 4);
    check("t5_hdr", 32'(words[0]), 3);
    check("t5_w3", 32'(words[3]), 32'h33);
    check("t5_done", 32'(done_cnt), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_reads", 32'(rd_total), 3);
    clear_stats();

    // Reset while the second data word is stalled
    @(posedge clock); #1;
    start = 1'b1; result_count = 8'd3; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = (nwords < 2);
      @(posedge clock); #1;
    end
    check("t6_pre_nwords", 32'(nwords), 2);
    check("t6_pre_valid", 32'(out_valid), 1);
    check("t6_pre_data", 32'(out_data), 32'h22);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_data",  32'(out_data), 0);
    check("t6_rst_last",  32'(out_last), 0);
    check("t6_rst_busy",  32'(busy), 0);
    check("t6_rst_done",  32'(done), 0);
    check("t6_rst_addr",  32'(ram_addr), 0);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    clear_stats();
    run_dump(8'd2, 0, 30);
    check("t6_nwords", 32'(nwords), 3);
    check("t6_w0", 32'(words[0]), 32'h02);
    check("t6_w1", 32'(words[1]), 32'h11);
    check("t6_w2", 32'(words[2]), 32'h22);
    check("t6_last", 32'(lasts[2]), 1);
    check("t6_base_read", 32'(rd_cnt[0]), 1);
    check("t6_done", 32'(done_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
